calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter ALU_TIMEOUT, default 16, max cycles spent in WAIT for alu_done.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  raw push-button, asynchronous to clk.
REQ-005 SHALL have port switches  input  16  mode/op/operand entry.
REQ-006 SHALL have port alu_mode  output  2  captured mode to datapath.
REQ-007 SHALL have port alu_op  output  4  captured operation select.
REQ-008 SHALL have port alu_a, alu_b  output  16 each  captured operands.
REQ-009 SHALL have port alu_start  output  1  one-cycle start pulse.
REQ-010 SHALL have ports alu_done  input  1 and alu_result  input  16; result valid while done high.
REQ-011 SHALL have ports tx_data  output  8, tx_valid  output  1, tx_ready  input  1  UART byte handshake.
REQ-012 SHALL have ports leds  output  16, state_o  output  3, err  output  1.

Function
REQ-013 SHALL synchronize enable through 2 flops, then rising-edge detect; a press SHALL cause exactly one FSM event regardless of hold length, effective on the 3rd rising clk edge after enable is first sampled high.
REQ-014 SHALL implement states IDLE=000, GET_OP=001, GET_A=010, GET_B=011, EXEC=100, WAIT=101, SHOW=110, SEND=111, visible on state_o.
REQ-015 IDLE + press: if switches[1:0] is 01 (arith) or 11 (logic), capture into alu_mode, clear err, go GET_OP; modes 00/10 SHALL be ignored (stay IDLE, nothing captured).
REQ-016 GET_OP + press: capture switches[3:0] into alu_op, go GET_A; GET_A + press: capture switches into alu_a, go GET_B; GET_B + press: capture switches into alu_b, go EXEC.
REQ-017 EXEC: assert alu_start for exactly one cycle, clear timeout counter, go WAIT unconditionally.
REQ-018 WAIT: alu_done sampled high -> latch alu_result, go SHOW; counter reaching ALU_TIMEOUT without done -> result=16'hFFFF, err=1, go SHOW; done and timeout same cycle -> done wins, err stays 0.
REQ-019 alu_done SHALL be ignored in every state except WAIT.
REQ-020 SHOW + press: go SEND; SHOW holds indefinitely without a press.
REQ-021 SEND: transmit result[15:8] then result[7:0]; tx_valid high with tx_data stable until a cycle with tx_valid&&tx_ready; after the second transfer, drop tx_valid and go IDLE in the same edge.
REQ-022 Presses in EXEC, WAIT and SEND SHALL be discarded, not queued.
REQ-023 leds SHALL be {13'b0, state} in IDLE..WAIT and the latched result in SHOW/SEND.
REQ-024 alu_mode/op/a/b SHALL hold captured values until next capture or reset.

Reset
REQ-025 rst high at a clk edge SHALL force state IDLE and zero every output (alu_*, tx_data, tx_valid, leds, state_o, err), sync flops, counter and result, from any state including mid-WAIT or mid-SEND.
REQ-026 A button held through reset release SHALL NOT generate an event until released and pressed again.

Verification
REQ-027 Add: press mode 1, op 0, A 4, B 5; ALU model returns 9 two cycles after start -> single alu_start with mode 01/op 0/a 4/b 5, state_o 110, leds 0x0009; press, tx_ready high -> bytes 0x00, 0x09, state_o 000.
REQ-028 AND: mode 3, op 0, A 4, B 5, model returns 4 -> leds 0x0004, err 0, bytes 0x00, 0x04.
REQ-029 Invalid mode 2 pressed -> state_o stays 000, alu_mode stays 00; enable held 50 cycles at valid mode -> exactly one transition.
REQ-030 Timeout: ALU never asserts done -> SHOW exactly ALU_TIMEOUT cycles after entering WAIT, err 1, leds 0xFFFF.
REQ-031 Backpressure: tx_ready low 10 cycles in SEND -> tx_valid held high, tx_data 0x00 stable, no byte loss; presses during SEND ignored.
REQ-032 rst pulsed during WAIT and during SEND -> next cycle all outputs 0, state_o 000, tx_valid 0.

Source files
------------

// File: rtl/calc_sequencer.sv
// Push-button calculator sequencer: captures mode, op and operands from switches,
// starts the ALU, waits for a result or timeout, shows it and sends it as two UART bytes.
module calc_sequencer #(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] switches,
    output logic [1:0]  alu_mode,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] leds,
    output logic [2:0]  state_o,
    output logic        err
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        GET_OP = 3'b001,
        GET_A  = 3'b010,
        GET_B  = 3'b011,
        EXEC   = 3'b100,
        WAIT   = 3'b101,
        SHOW   = 3'b110,
        SEND   = 3'b111
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      result_q, result_d;
    logic             byte_sel_q, byte_sel_d;
    logic [1:0]       alu_mode_q, alu_mode_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [15:0]      alu_a_q, alu_a_d;
    logic [15:0]      alu_b_q, alu_b_d;
    logic             alu_start_q, alu_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [15:0]      leds_q, leds_d;
    logic             err_q, err_d;
    logic             press;

    // The button only arms once the synchronizer has seen it released after reset,
    // so a press held through reset release never becomes an event.
    assign press = sync2_q & ~prev_q & armed_q;

    always_comb begin
        // NOTE: every *_d starts from its *_q so no branch below can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        byte_sel_d  = byte_sel_q;
        alu_mode_d  = alu_mode_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_start_d = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        err_d       = err_q;

        sync1_d = enable;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);

        case (state_q)
            IDLE: begin
                // Modes 01 (arith) and 11 (logic) both have bit 0 set.
                if (press && switches[0]) begin
                    alu_mode_d = switches[1:0];
                    err_d      = 1'b0;
                    state_d    = GET_OP;
                end
            end
            GET_OP: begin
                if (press) begin
                    alu_op_d = switches[3:0];
                    state_d  = GET_A;
                end
            end
            GET_A: begin
                if (press) begin
                    alu_a_d = switches;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (press) begin
                    alu_b_d     = switches;
                    alu_start_d = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = 16'hFFFF;
                    err_d    = 1'b1;
                    state_d  = SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (press) begin
                    tx_data_d  = result_q[15:8];
                    tx_valid_d = 1'b1;
                    byte_sel_d = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (!byte_sel_q) begin
                        tx_data_d  = result_q[7:0];
                        byte_sel_d = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        leds_d = (state_d == SHOW || state_d == SEND) ? result_d : {13'b0, state_d};
    end

    // NOTE: reset is synchronous and clears every flop, including the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            byte_sel_q  <= 1'b0;
            alu_mode_q  <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_start_q <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            leds_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            byte_sel_q  <= byte_sel_d;
            alu_mode_q  <= alu_mode_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_start_q <= alu_start_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            leds_q      <= leds_d;
            err_q       <= err_d;
        end
    end

    assign alu_mode  = alu_mode_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_start = alu_start_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign leds      = leds_q;
    assign state_o   = state_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: random transactions against a behavioural
// ALU/sequencer model, plus directed reset, timeout, backpressure and button cases.
module tb_calc_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] switches;
    logic [1:0]  alu_mode;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] leds;
    logic [2:0]  state_o;
    logic        err;

    always #5 clk = ~clk;

    calc_sequencer #(.ALU_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .enable(enable), .switches(switches),
        .alu_mode(alu_mode), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .leds(leds), .state_o(state_o), .err(err)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } start_t;

    typedef struct packed {
        logic [15:0] leds;
        logic        err;
        logic [7:0]  wait_len;
    } show_t;

    start_t     exp_start[$];
    show_t      exp_show[$];
    logic [7:0] exp_bytes[$];

    int checks = 0;
    int errors = 0;

    int   alu_lat    = 1;
    int   pending    = 0;
    logic stray_req  = 1'b0;
    int   ready_mode = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [1:0] mode, input logic [3:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
        if (mode == 2'b01) begin
            case (op)
                4'd0:    return a + b;
                4'd1:    return a - b;
                default: return a + b + 16'(op);
            endcase
        end else begin
            case (op)
                4'd0:    return a & b;
                4'd1:    return a | b;
                default: return a ^ b;
            endcase
        end
    endfunction

    // ALU model: done pulses in the alu_lat-th cycle after the start cycle; 0 means never.
    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
        forever begin
            @(posedge clk);
            #2;
            alu_done = 1'b0;
            if (rst) begin
                pending = 0;
            end else if (alu_start) begin
                pending = alu_lat;
            end else if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    alu_done   = 1'b1;
                    alu_result = ref_alu(alu_mode, alu_op, alu_a, alu_b);
                end
            end
            if (stray_req) begin
                alu_done   = 1'b1;
                alu_result = 16'hDEAD;
                stray_req  = 1'b0;
            end
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts the ALU, enters SHOW or moves a byte.
    initial begin
        logic [2:0] prev_state;
        int         wcnt;
        start_t     s;
        show_t      e;
        logic [7:0] eb;
        prev_state = '0;
        wcnt       = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (alu_start) begin
                    if (exp_start.size() == 0) begin
                        check("unexpected alu_start", 72'(1), 72'(0));
                    end else begin
                        s = exp_start.pop_front();
                        check("alu_start fields", 72'({alu_mode, alu_op, alu_a, alu_b}), 72'(s));
                    end
                end
                if (state_o == 3'd4) wcnt = 0;
                else if (state_o == 3'd5) wcnt++;
                if (state_o == 3'd6 && prev_state != 3'd6) begin
                    if (exp_show.size() == 0) begin
                        check("unexpected SHOW", 72'(1), 72'(0));
                    end else begin
                        e = exp_show.pop_front();
                        check("show leds", 72'(leds), 72'(e.leds));
                        check("show err", 72'(err), 72'(e.err));
                        check("wait cycles", 72'(wcnt), 72'(e.wait_len));
                    end
                end
                if (tx_valid && tx_ready) begin
                    if (exp_bytes.size() == 0) begin
                        check("unexpected tx byte", 72'(1), 72'(0));
                    end else begin
                        eb = exp_bytes.pop_front();
                        check("tx byte", 72'(tx_data), 72'(eb));
                    end
                end
            end
            prev_state = state_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] sw, input int hold);
        switches = sw;
        enable   = 1'b1;
        tick(hold);
        enable   = 1'b0;
        tick(5);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        for (int i = 0; i < budget && state_o !== target; i++) tick(1);
        check(name, 72'(state_o), 72'(target));
    endtask

    task automatic check_zero(input string name);
        check(name, 72'({alu_mode, alu_op, alu_a, alu_b, alu_start, tx_data, tx_valid,
                         leds, state_o, err}), 72'(0));
    endtask

    task automatic pulse_reset(input string name);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_zero(name);
        exp_start.delete();
        exp_show.delete();
        exp_bytes.delete();
        tick(4);
    endtask

    task automatic load(input logic [1:0] mode, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input int lat);
        press({14'h0, mode}, $urandom_range(1, 6));
        check("state after mode press", 72'(state_o), 72'(1));
        check("leds after mode press", 72'(leds), 72'(1));
        check("captured mode", 72'(alu_mode), 72'(mode));
        press({12'h0, op}, $urandom_range(1, 6));
        check("state after op press", 72'(state_o), 72'(2));
        stray_req = 1'b1;
        tick(3);
        check("stray done ignored", 72'(state_o), 72'(2));
        press(a, $urandom_range(1, 6));
        check("state after A press", 72'(state_o), 72'(3));
        check("leds after A press", 72'(leds), 72'(3));
        exp_start.push_back(start_t'{mode, op, a, b});
        alu_lat = lat;
        press(b, $urandom_range(1, 4));
    endtask

    task automatic push_show(input logic [1:0] mode, input logic [3:0] op,
                             input logic [15:0] a, input logic [15:0] b, input int lat,
                             output logic [15:0] res);
        logic tmo;
        tmo = (lat == 0 || lat > T);
        res = tmo ? 16'hFFFF : ref_alu(mode, op, a, b);
        exp_show.push_back(show_t'{res, tmo, 8'(tmo ? T : lat)});
    endtask

    task automatic run_txn(input logic [1:0] mode, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b, input int lat,
                           input bit bp);
        logic [15:0] res;
        int          saved_mode;
        push_show(mode, op, a, b, lat, res);
        load(mode, op, a, b, lat);
        wait_state(3'd6, T + 30, "reach SHOW");
        tick(2);
        check("SHOW holds without press", 72'(state_o), 72'(6));
        check("leds show result", 72'(leds), 72'(res));
        saved_mode = ready_mode;
        if (bp) ready_mode = 2;
        exp_bytes.push_back(res[15:8]);
        exp_bytes.push_back(res[7:0]);
        press(16'($urandom), $urandom_range(1, 6));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                check("backpressure tx_valid", 72'(tx_valid), 72'(1));
                check("backpressure tx_data", 72'(tx_data), 72'(res[15:8]));
                tick(1);
            end
            press(16'($urandom), 2);
            check("press in SEND ignored", 72'(state_o), 72'(7));
            ready_mode = saved_mode;
        end
        wait_state(3'd0, 100, "back to IDLE");
        tick(3);
        check("IDLE after SEND", 72'(state_o), 72'(0));
        check("tx_valid low in IDLE", 72'(tx_valid), 72'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        int          trans;
        logic [2:0]  last;

        rst      = 1'b1;
        enable   = 1'b0;
        switches = '0;
        tick(3);
        rst = 1'b0;
        check_zero("reset state");
        tick(4);

        run_txn(2'b01, 4'd0, 16'd4, 16'd5, 2, 1'b0);
        run_txn(2'b11, 4'd0, 16'd4, 16'd5, 3, 1'b0);
        run_txn(2'b01, 4'd1, 16'h1234, 16'h0042, 0, 1'b0);
        run_txn(2'b11, 4'd1, 16'h0F0F, 16'h3000, T, 1'b0);
        run_txn(2'b01, 4'd2, 16'h8000, 16'h0001, T + 2, 1'b0);
        run_txn(2'b01, 4'd1, 16'h1234, 16'h0042, 1, 1'b1);

        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            run_txn($urandom_range(0, 1) ? 2'b11 : 2'b01, 4'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom), $urandom_range(0, T + 2), 1'b0);
        end
        ready_mode = 0;
        check("scoreboard drained", 72'(exp_start.size() + exp_show.size() + exp_bytes.size()),
              72'(0));

        // Reset in the middle of WAIT.
        load(2'b01, 4'd0, 16'd7, 16'd8, 0);
        check("in WAIT before reset", 72'(state_o), 72'(5));
        pulse_reset("reset during WAIT");

        // Reset in the middle of SEND.
        push_show(2'b11, 4'd2, 16'h00FF, 16'h0F0F, 1, res);
        load(2'b11, 4'd2, 16'h00FF, 16'h0F0F, 1);
        wait_state(3'd6, T + 30, "reach SHOW before SEND reset");
        ready_mode = 2;
        press(16'h0, 2);
        check("in SEND before reset", 72'(state_o), 72'(7));
        pulse_reset("reset during SEND");
        ready_mode = 0;

        // Button held through reset release.
        switches = 16'h0001;
        enable   = 1'b1;
        rst      = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("held through reset: no event", 72'(state_o), 72'(0));
        enable = 1'b0;
        tick(5);
        check("release after reset: no event", 72'(state_o), 72'(0));
        press(16'h0001, 2);
        check("fresh press after reset", 72'(state_o), 72'(1));
        pulse_reset("reset from GET_OP");

        // Invalid mode and a long hold.
        press(16'h0002, 3);
        check("invalid mode stays IDLE", 72'(state_o), 72'(0));
        check("invalid mode not captured", 72'(alu_mode), 72'(0));
        switches = 16'h0001;
        enable   = 1'b1;
        trans    = 0;
        last     = state_o;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (state_o != last) trans++;
            last = state_o;
        end
        enable = 1'b0;
        tick(5);
        check("transitions during long hold", 72'(trans), 72'(1));
        check("state after long hold", 72'(state_o), 72'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
